// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode pipe: instruction field
// positions, the PC increment and the decoded-field record.
package fd_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  localparam int PC_STEP  = 4;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } fd_fields_t;

  // Split a 32-bit instruction word into its named fields.
  function automatic fd_fields_t fd_decode(input logic [31:0] inst);
    fd_fields_t f;
    f.opcode = inst[OPC_HI:OPC_LO];
    f.rs     = inst[RS_HI:RS_LO];
    f.rt     = inst[RT_HI:RT_LO];
    f.rd     = inst[RD_HI:RD_LO];
    f.shamt  = inst[SHAMT_HI:SHAMT_LO];
    f.funct  = inst[FUNCT_HI:FUNCT_LO];
    return f;
  endfunction

endpackage

// File: rtl/fd_regfile.sv
// Register file: two combinational read ports, one write port, register 0
// hard-wired to zero, out-of-range indices read 0 / drop writes.
// Optional macro FD_WB_BYPASS_EN: a same-cycle write is forwarded to a
// matching read port; without it a read sees the pre-write value.
module fd_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] arr1_s;
  logic [DATA_W-1:0] arr2_s;

  // Next register contents: apply the write port, never touch entry 0.
  always_comb begin
    regs_d[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = (we && (int'(waddr) == i)) ? wdata : regs_q[i];
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Array read: index 0 and indices past the last entry return zero.
  always_comb begin
    arr1_s = '0;
    arr2_s = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      arr1_s = (int'(raddr1) == i) ? regs_q[i] : arr1_s;
      arr2_s = (int'(raddr2) == i) ? regs_q[i] : arr2_s;
    end
  end

`ifdef FD_WB_BYPASS_EN
  logic byp1_s;
  logic byp2_s;

  // Forward the in-flight write to a read of the same, valid, non-zero entry.
  always_comb begin
    byp1_s = we && (raddr1 != 5'd0) && (int'(raddr1) < NUM_REGS)
             && (int'(waddr) == int'(raddr1));
    byp2_s = we && (raddr2 != 5'd0) && (int'(raddr2) < NUM_REGS)
             && (int'(waddr) == int'(raddr2));
    rdata1 = byp1_s ? wdata : arr1_s;
    rdata2 = byp2_s ? wdata : arr2_s;
  end
`else
  // Reads see the stored value; a same-cycle write lands at the edge.
  always_comb begin
    rdata1 = arr1_s;
    rdata2 = arr2_s;
  end
`endif

endmodule

// File: rtl/fetch_decode_pipe.sv
// Two-stage fetch/decode pipe: PC -> IF/ID -> ID/EX with a ready/valid
// output handshake, branch redirect and a writeback port into fd_regfile.
// Optional macro FD_WB_BYPASS_EN enables writeback-to-read forwarding.
module fetch_decode_pipe
  import fd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 7,
  parameter int NUM_REGS = 32,
  parameter int RESET_PC = 0,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imemAddr,
  input  logic [DATA_W-1:0] imemData,
  input  logic              redirectValid,
  input  logic [PC_W-1:0]   redirectPc,
  input  logic              regWrite,
  input  logic [REG_AW-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [REG_AW-1:0] rdOut,
  output logic [5:0]        funct,
  output logic [5:0]        opcode
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ifid_inst_q, ifid_inst_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
  logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [5:0]        ex_funct_q, ex_funct_d;
  logic [5:0]        ex_opcode_q, ex_opcode_d;
  logic              ex_valid_q, ex_valid_d;

  fd_fields_t        dec_s;
  logic [DATA_W-1:0] rf_rd1_s;
  logic [DATA_W-1:0] rf_rd2_s;
  logic              advance_s;
  logic              unused_s;

  assign dec_s     = fd_decode(ifid_inst_q[31:0]);
  assign advance_s = !ex_valid_q || outReady;
  // shamt and the rd bits above the register index width have no consumer.
  assign unused_s  = ^{dec_s.shamt, dec_s.rd};

  fd_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (dec_s.rs),
    .raddr2 (dec_s.rt),
    .we     (regWrite),
    .waddr  (writeReg),
    .wdata  (writeData),
    .rdata1 (rf_rd1_s),
    .rdata2 (rf_rd2_s)
  );

  // Pipeline next state: redirect beats everything, else advance or hold.
  always_comb begin
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    ex_rd1_d     = ex_rd1_q;
    ex_rd2_d     = ex_rd2_q;
    ex_rd_d      = ex_rd_q;
    ex_funct_d   = ex_funct_q;
    ex_opcode_d  = ex_opcode_q;
    ex_valid_d   = ex_valid_q;
    if (redirectValid) begin
      // Squash both stages; the new PC is forced word aligned.
      pc_d         = {redirectPc[PC_W-1:2], 2'b00};
      ifid_valid_d = 1'b0;
      ex_valid_d   = 1'b0;
    end else if (advance_s) begin
      pc_d         = pc_q + PC_W'(PC_STEP);
      ifid_inst_d  = imemData;
      ifid_valid_d = 1'b1;
      ex_rd1_d     = rf_rd1_s;
      ex_rd2_d     = rf_rd2_s;
      ex_rd_d      = dec_s.rd[REG_AW-1:0];
      ex_funct_d   = dec_s.funct;
      ex_opcode_d  = dec_s.opcode;
      ex_valid_d   = ifid_valid_q;
    end else begin
      // Downstream stalled with a valid output: everything holds.
      pc_d         = pc_q;
      ex_valid_d   = ex_valid_q;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= PC_W'(RESET_PC);
      ifid_inst_q  <= '0;
      ifid_valid_q <= 1'b0;
      ex_rd1_q     <= '0;
      ex_rd2_q     <= '0;
      ex_rd_q      <= '0;
      ex_funct_q   <= 6'd0;
      ex_opcode_q  <= 6'd0;
      ex_valid_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      ex_rd1_q     <= ex_rd1_d;
      ex_rd2_q     <= ex_rd2_d;
      ex_rd_q      <= ex_rd_d;
      ex_funct_q   <= ex_funct_d;
      ex_opcode_q  <= ex_opcode_d;
      ex_valid_q   <= ex_valid_d;
    end
  end

  assign imemAddr  = pc_q;
  assign outValid  = ex_valid_q;
  assign readData1 = ex_rd1_q;
  assign readData2 = ex_rd2_q;
  assign rdOut     = ex_rd_q;
  assign funct     = ex_funct_q;
  assign opcode    = ex_opcode_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Self-checking bench for fetch_decode_pipe: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the fetch stream and register contents.
module tb_fetch_decode_pipe;

  localparam int DATA_W   = 32;
  localparam int PC_W     = 7;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PC_W-1:0]   imemAddr;
  logic [DATA_W-1:0] imemData;
  logic              redirectValid;
  logic [PC_W-1:0]   redirectPc;
  logic              regWrite;
  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [REG_AW-1:0] rdOut;
  logic [5:0]        funct;
  logic [5:0]        opcode;

  logic [31:0] imem [32];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imemData = imem[imemAddr[6:2]];

  fetch_decode_pipe #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NUM_REGS(NUM_REGS), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imemAddr(imemAddr), .imemData(imemData),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .outValid(outValid), .outReady(outReady),
    .readData1(readData1), .readData2(readData2),
    .rdOut(rdOut), .funct(funct), .opcode(opcode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PC_W-1:0] m_pc;
  logic [31:0]     m_inst;
  logic            m_v1;
  logic            m_ov;
  logic [31:0]     m_r1, m_r2;
  logic [4:0]      m_rd;
  logic [5:0]      m_funct, m_opc;
  logic [31:0]     m_regs [32];

  // Value a decode-stage read of register idx observes this cycle.
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef FD_WB_BYPASS_EN
    if (regWrite && (writeReg == idx)) return writeData;
`endif
    return m_regs[idx];
  endfunction

  // Model: fetch stream advancing by 4, squashed by redirect, frozen on stall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 7'd0; m_inst <= 32'd0; m_v1 <= 1'b0; m_ov <= 1'b0;
      m_r1 <= 32'd0; m_r2 <= 32'd0; m_rd <= 5'd0; m_funct <= 6'd0; m_opc <= 6'd0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else begin
      if (regWrite && (writeReg != 5'd0)) m_regs[writeReg] <= writeData;
      if (redirectValid) begin
        m_v1 <= 1'b0;
        m_ov <= 1'b0;
        m_pc <= {redirectPc[6:2], 2'b00};
      end else if (!m_ov || outReady) begin
        m_ov    <= m_v1;
        m_r1    <= m_read(m_inst[25:21]);
        m_r2    <= m_read(m_inst[20:16]);
        m_rd    <= m_inst[15:11];
        m_funct <= m_inst[5:0];
        m_opc   <= m_inst[31:26];
        m_inst  <= imem[m_pc[6:2]];
        m_v1    <= 1'b1;
        m_pc    <= m_pc + 7'd4;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("imemAddr", imemAddr, m_pc);
    check("outValid", outValid, m_ov);
    if (m_ov || !rst_n) begin
      check("readData1", readData1, m_r1);
      check("readData2", readData2, m_r2);
      check("rdOut", rdOut, m_rd);
      check("funct", funct, m_funct);
      check("opcode", opcode, m_opc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [PC_W-1:0] pc);
    redirectValid = 1'b1;
    redirectPc    = pc;
    cyc();
    redirectValid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; redirectValid = 1'b0; redirectPc = 7'd0; regWrite = 1'b0;
    writeReg = 5'd0; writeData = 32'd0; outReady = 1'b0;
    for (int i = 0; i < 32; i++) imem[i] = $urandom;
    imem[0]  = 32'h012A4020;   // add rd=8 rs=9 rt=10
    imem[16] = 32'h012A4020;   // same at 0x40
    imem[20] = 32'h00091820;   // rs=0 rt=9 rd=3 at 0x50

    repeat (3) cyc();
    check("rst_imemAddr", imemAddr, 32'h0);
    check("rst_outValid", outValid, 32'h0);
    check("rst_readData1", readData1, 32'h0);
    check("rst_rdOut", rdOut, 32'h0);
    check("rst_opcode", opcode, 32'h0);

    // Reset release and first instruction latency.
    rst_n = 1'b1; outReady = 1'b1;
    #1 check("rel_imemAddr", imemAddr, 32'h00);
    cyc(); check("lat_addr4", imemAddr, 32'h04); check("lat_ov0", outValid, 32'h0);
    cyc(); check("lat_addr8", imemAddr, 32'h08); check("lat_ov1", outValid, 32'h1);
    check("lat_rdOut", rdOut, 32'd8); check("lat_funct", funct, 32'h20);
    check("lat_opcode", opcode, 32'h0);

    // Three-cycle stall with a full pipe.
    outReady = 1'b0;
    repeat (3) begin
      cyc();
      check("stall_addr", imemAddr, 32'h08);
      check("stall_rdOut", rdOut, 32'd8);
      check("stall_ov", outValid, 32'h1);
    end
    outReady = 1'b1;
    cyc(); check("rel_inst1_rd", rdOut, {27'd0, imem[1][15:11]});
    check("rel_inst1_funct", funct, {26'd0, imem[1][5:0]});
    cyc(); check("rel_inst2_rd", rdOut, {27'd0, imem[2][15:11]});

    // Redirect while stalled.
    outReady = 1'b0; cyc();
    redirect_to(7'h23);
    check("redir_ov", outValid, 32'h0); check("redir_addr", imemAddr, 32'h20);
    outReady = 1'b1;
    cyc(); check("redir_addr24", imemAddr, 32'h24); check("redir_ov0", outValid, 32'h0);
    cyc(); check("redir_ov1", outValid, 32'h1);
    check("redir_opcode", opcode, {26'd0, imem[8][31:26]});
    check("redir_rd", rdOut, {27'd0, imem[8][15:11]});

    // Writeback to rs=9 in the decode cycle.
    redirect_to(7'h40);
    cyc();
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'hDEADBEEF;
    cyc(); regWrite = 1'b0;
`ifdef FD_WB_BYPASS_EN
    check("bypass_rd1", readData1, 32'hDEADBEEF);
`else
    check("bypass_rd1", readData1, 32'h0);
`endif
    redirect_to(7'h40); cyc(); cyc();
    check("wb_visible", readData1, 32'hDEADBEEF);

    // Register 0 ignores writes, including a same-cycle one.
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
    redirect_to(7'h50); cyc(); cyc();
    regWrite = 1'b0;
    check("r0_rd1", readData1, 32'h0);
    check("r0_rd2", readData2, 32'hDEADBEEF);

    // PC wrap and asynchronous reset mid-stream.
    redirect_to(7'h7C);
    check("wrap_pre", imemAddr, 32'h7C);
    cyc(); check("wrap", imemAddr, 32'h00);
    cyc();
    rst_n = 1'b0;
    #1 check("async_ov", outValid, 32'h0); check("async_addr", imemAddr, 32'h0);
    check("async_rd1", readData1, 32'h0);
    cyc(); rst_n = 1'b1;
    cyc(); cyc();
    check("post_rst_ov", outValid, 32'h1); check("post_rst_rd", rdOut, 32'd8);
    check("post_rst_rd1", readData1, 32'h0);

    // Randomized traffic, checked by the every-cycle comparator.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      outReady      = ($urandom_range(0, 3) != 0);
      redirectValid = ($urandom_range(0, 19) == 0);
      redirectPc    = 7'($urandom);
      regWrite      = ($urandom_range(0, 2) == 0);
      writeReg      = ($urandom_range(0, 1) == 0) ? m_inst[25:21] : 5'($urandom);
      writeData     = $urandom;
      rst_n         = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1'b1; redirectValid = 1'b0; regWrite = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_pipe.md
FETCH_DECODE_PIPE -- requirements
Module: fetch_decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction and register data width.
REQ-002 SHALL have parameter PC_W, default 7, meaning byte-address width of PC and instruction port.
REQ-003 SHALL have parameter NUM_REGS, default 32, meaning register-file entries; index width REG_AW = clog2(NUM_REGS), at most 5.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning PC value loaded by reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port imemAddr, output, PC_W, current PC to instruction memory.
REQ-008 SHALL have port imemData, input, DATA_W, instruction at imemAddr, combinational same-cycle read.
REQ-009 SHALL have ports redirectValid (input, 1) and redirectPc (input, PC_W): branch/jump redirect request.
REQ-010 SHALL have ports regWrite (input, 1), writeReg (input, REG_AW) and writeData (input, DATA_W): writeback port.
REQ-011 SHALL have ports outValid (output, 1) and outReady (input, 1): decode-output handshake.
REQ-012 SHALL have ports readData1 and readData2 (output, DATA_W each), rdOut (output, REG_AW), funct (output, 6) and opcode (output, 6): decoded fields.

Function
REQ-013 SHALL hold an IF/ID register (instruction, valid) and an ID/EX register (readData1/2, rdOut, funct, opcode, valid).
REQ-014 SHALL take rs = inst[25:21], rt = inst[20:16], rd = inst[15:11], funct = inst[5:0], opcode = inst[31:26].
REQ-015 SHALL use advance = !outValid || outReady; when advance is low, PC, IF/ID and ID/EX SHALL hold.
REQ-016 SHALL, on advance, load imemData into IF/ID with valid=1 and set PC to PC+4 modulo 2^PC_W.
REQ-017 SHALL, on advance, load ID/EX from IF/ID, with register reads indexed by rs and rt.
REQ-018 SHALL give a latency of 2 edges from PC presentation to outValid, with throughput of 1 per cycle under outReady=1.
REQ-019 SHALL, on redirectValid, clear both valid bits, load PC with redirectPc with bits [1:0] forced to 0, and ignore advance.
REQ-020 SHALL, when redirectValid and a stall coincide, apply the redirect.
REQ-021 SHALL, when regWrite=1 and writeReg!=0, write writeData at the clock edge, independent of advance or redirect.
REQ-022 SHALL make register 0 always read 0 and ignore writes to it.
REQ-023 SHALL ignore rs, rt or writeReg indices of NUM_REGS or above: reads return 0 and writes are dropped.
REQ-024 SHALL keep outValid from dropping without a handshake, except on redirect.

Reset
REQ-025 SHALL, on rst_n low (immediate, asynchronous), set PC=RESET_PC, both valid bits to 0, all ID/EX fields to 0 and all registers to 0.
REQ-026 SHALL, as a result, drive outValid=0, readData1/2=0, rdOut=0, funct=0, opcode=0 and imemAddr=RESET_PC during reset.
REQ-027 SHALL, on reset mid-stream, discard in-flight instructions; the first post-reset output SHALL be the instruction at RESET_PC.

Configuration
REQ-028 SHALL, with macro FD_WB_BYPASS_EN defined, forward writeData to a read in the same cycle when regWrite=1 and writeReg equals rs/rt and is not 0.
REQ-029 SHALL, without FD_WB_BYPASS_EN, return the pre-write register value for a same-cycle read; the new value is visible from the next cycle.

Structure
REQ-030 SHALL use a shared package fd_pkg holding field-position constants (OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, FUNCT_HI/LO), PC_STEP=4 and a decoded-fields struct typedef.
REQ-031 SHALL use sub-module fd_regfile (parametrised NUM_REGS, DATA_W; two read ports, one write port, asynchronous reset), with bypass logic inside it.

Verification
REQ-032 SHALL cover reset release, imem[0]=0x012A4020 (add rd=8 rs=9 rt=10) -> outValid=1 two edges later, rdOut=8, funct=0x20, opcode=0, imemAddr stepping 0,4,8.
REQ-033 SHALL cover 3-cycle hold of outReady=0 with a full pipe -> outputs and imemAddr stable, no instruction lost or duplicated after release.
REQ-034 SHALL cover redirectValid with redirectPc=0x23 during a stall -> next edge outValid=0 and imemAddr=0x20; the instruction at 0x20 appears 2 edges later.
REQ-035 SHALL cover regWrite to reg 9 with 0xDEADBEEF in the same cycle as rs=9 decode -> readData1=0xDEADBEEF with FD_WB_BYPASS_EN, old value 0 without.
REQ-036 SHALL cover a write to reg 0 with 0xFFFFFFFF, then reading rs=0 -> readData1=0.
REQ-037 SHALL cover PC_W=7 at PC=0x7C advancing -> imemAddr wraps to 0x00; rst_n pulsed mid-stream -> outValid=0 immediately.
